// File: rtl/encoder8x3_seq_if.sv
// Bus bundle between a request source/consumer and encoder8x3_seq.
// The master drives requests and acknowledges; the slave (encoder) returns the code.
interface encoder8x3_seq_if;
  logic       enable;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       miss;

  modport master (
    output enable, req, ack,
    input  code, valid, pending, miss
  );

  modport slave (
    input  enable, req, ack,
    output code, valid, pending, miss
  );
endinterface

// File: rtl/encoder8x3_seq.sv
// Sequential 8-to-3 encoder: sticky pending register, held grant until ack.
// Define ENCODER8X3_ROUND_ROBIN_EN to replace fixed priority with rotating priority.
module encoder8x3_seq #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input logic             clk,
  input logic             rst,
  encoder8x3_seq_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pending_q, pending_d;
  logic       miss_q, miss_d;
  logic [7:0] clr;
  logic [7:0] pendNext;
  logic [2:0] grant;
  logic       busy;

  assign busy = (state_q == BUSY);

`ifdef ENCODER8X3_ROUND_ROBIN_EN
  localparam logic [2:0] PTR_RESET = PRIO_HIGH ? 3'd0 : 3'd7;

  logic [2:0] ptr_q, ptr_d;

  // Search starts one step past the last grant; step 8 wraps back onto base itself.
  function automatic logic [2:0] selRr(input logic [7:0] v, input logic [2:0] base);
    logic [2:0] idx;
    logic [2:0] cand;
    idx = base;
    for (int s = 8; s >= 1; s--) begin
      cand = PRIO_HIGH ? (base - 3'(s)) : (base + 3'(s));
      if (v[cand]) idx = cand;
    end
    return idx;
  endfunction
`else
  function automatic logic [2:0] selFixed(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (PRIO_HIGH) begin
        if (v[i]) idx = 3'(i);
      end else begin
        if (v[7-i]) idx = 3'(7 - i);
      end
    end
    return idx;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pending_d = pending_q;
    miss_d    = 1'b0;
    clr       = 8'd0;
    pendNext  = pending_q;
    grant     = 3'd0;
`ifdef ENCODER8X3_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    if (bus.enable) begin
      if (busy && bus.ack) clr = 8'd1 << code_q;
      // Set wins over clear: a request on the bit being acked keeps it pending.
      pendNext  = (pending_q & ~clr) | bus.req;
      pending_d = pendNext;
      miss_d    = |(bus.req & pending_q & ~clr);
`ifdef ENCODER8X3_ROUND_ROBIN_EN
      if (busy && bus.ack) ptr_d = code_q;
      grant = selRr(pendNext, ptr_d);
`else
      grant = selFixed(pendNext);
`endif
      case (state_q)
        IDLE: begin
          if (pendNext != 8'd0) begin
            code_d  = grant;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (bus.ack) begin
            if (pendNext != 8'd0) code_d = grant;
            else                  state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= 3'd0;
      pending_q <= 8'd0;
      miss_q    <= 1'b0;
`ifdef ENCODER8X3_ROUND_ROBIN_EN
      ptr_q     <= PTR_RESET;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      miss_q    <= miss_d;
`ifdef ENCODER8X3_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  // enable gates valid combinationally so a frozen grant is hidden but not lost.
  assign bus.code    = code_q;
  assign bus.valid   = busy & bus.enable;
  assign bus.pending = pending_q;
  assign bus.miss    = miss_q;

endmodule
